// File: rtl/pl_rv32_fetch_stage.sv
// RV32 instruction-fetch stage: sequential PC generation, credit-limited imem
// request/grant/response handshake and a small {pc, instr} FIFO feeding decode.
module pl_rv32_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        id_valid_o,
   output logic [31:0] id_instr_o,
   output logic [31:0] id_pc_o,
   input  logic        id_ready_i
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;

   localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0]      PC_STEP   = 32'h0000_0004;
   localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(DEPTH);

   logic [31:0]      fetch_pc_r, resp_pc_r;
   logic [CNT_W-1:0] outstanding_r, discard_r, count_r;
   logic [PTR_W-1:0] rd_ptr_r, wr_ptr_r;
   logic [31:0]      pc_mem_r    [DEPTH];
   logic [31:0]      instr_mem_r [DEPTH];

   logic [31:0]      fetch_pc_n_s, resp_pc_n_s, target_pc_s;
   logic [CNT_W-1:0] outstanding_n_s, discard_n_s, count_n_s;
   logic [PTR_W-1:0] rd_ptr_n_s, wr_ptr_n_s;
   logic [SUM_W-1:0] credit_sum_s;
   logic             req_s, issue_s, resp_s, keep_s, valid_s, pop_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_LAST) begin
         return PTR_ZERO;
      end else begin
         return ptr + PTR_ONE;
      end
   endfunction

   // Handshake qualifiers for the current cycle.
   always_comb begin
      credit_sum_s = {1'b0, outstanding_r} + {1'b0, count_r};
      target_pc_s  = {redirect_pc_i[31:2], 2'b00};
      // A response with nothing outstanding is a protocol error; ignore it.
      resp_s       = imem_rvalid_i && (outstanding_r != CNT_ZERO);
      if (rst || redirect_i) begin
         req_s = 1'b0;
      end else if (credit_sum_s < DEPTH_SUM) begin
         req_s = 1'b1;
      end else begin
         req_s = 1'b0;
      end
      issue_s = req_s && imem_gnt_i;
      keep_s  = resp_s && !redirect_i && (discard_r == CNT_ZERO);
      valid_s = (count_r != CNT_ZERO) && !redirect_i;
      pop_s   = valid_s && id_ready_i;
   end

   assign imem_req_o  = req_s;
   assign imem_addr_o = fetch_pc_r;
   assign id_valid_o  = valid_s;
   assign id_instr_o  = (count_r != CNT_ZERO) ? instr_mem_r[rd_ptr_r] : NOP_INSTR;
   assign id_pc_o     = (count_r != CNT_ZERO) ? pc_mem_r[rd_ptr_r] : resp_pc_r;

   // Next-state for PCs, credit counters and FIFO pointers.
   always_comb begin
      fetch_pc_n_s    = fetch_pc_r;
      resp_pc_n_s     = resp_pc_r;
      discard_n_s     = discard_r;
      count_n_s       = count_r;
      rd_ptr_n_s      = rd_ptr_r;
      wr_ptr_n_s      = wr_ptr_r;
      outstanding_n_s = outstanding_r;

      if (redirect_i) begin
         // Everything still in flight belongs to the old path, except a word landing now.
         fetch_pc_n_s = target_pc_s;
         resp_pc_n_s  = target_pc_s;
         discard_n_s  = outstanding_r - (resp_s ? CNT_ONE : CNT_ZERO);
         count_n_s    = CNT_ZERO;
         rd_ptr_n_s   = PTR_ZERO;
         wr_ptr_n_s   = PTR_ZERO;
      end else begin
         if (issue_s) begin
            fetch_pc_n_s = fetch_pc_r + PC_STEP;
         end else begin
            fetch_pc_n_s = fetch_pc_r;
         end
         if (keep_s) begin
            resp_pc_n_s = resp_pc_r + PC_STEP;
            wr_ptr_n_s  = ptr_inc(wr_ptr_r);
         end else begin
            resp_pc_n_s = resp_pc_r;
            wr_ptr_n_s  = wr_ptr_r;
         end
         if (resp_s && (discard_r != CNT_ZERO)) begin
            discard_n_s = discard_r - CNT_ONE;
         end else begin
            discard_n_s = discard_r;
         end
         if (pop_s) begin
            rd_ptr_n_s = ptr_inc(rd_ptr_r);
         end else begin
            rd_ptr_n_s = rd_ptr_r;
         end
         case ({keep_s, pop_s})
            2'b10:   count_n_s = count_r + CNT_ONE;
            2'b01:   count_n_s = count_r - CNT_ONE;
            default: count_n_s = count_r;
         endcase
      end

      case ({issue_s, resp_s})
         2'b10:   outstanding_n_s = outstanding_r + CNT_ONE;
         2'b01:   outstanding_n_s = outstanding_r - CNT_ONE;
         default: outstanding_n_s = outstanding_r;
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_r    <= RESET_PC;
         resp_pc_r     <= RESET_PC;
         outstanding_r <= CNT_ZERO;
         discard_r     <= CNT_ZERO;
         count_r       <= CNT_ZERO;
         rd_ptr_r      <= PTR_ZERO;
         wr_ptr_r      <= PTR_ZERO;
      end else begin
         fetch_pc_r    <= fetch_pc_n_s;
         resp_pc_r     <= resp_pc_n_s;
         outstanding_r <= outstanding_n_s;
         discard_r     <= discard_n_s;
         count_r       <= count_n_s;
         rd_ptr_r      <= rd_ptr_n_s;
         wr_ptr_r      <= wr_ptr_n_s;
      end
   end

   // FIFO storage; the credit rule guarantees the write slot is free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            pc_mem_r[i]    <= 32'h0000_0000;
            instr_mem_r[i] <= 32'h0000_0000;
         end
      end else if (keep_s) begin
         pc_mem_r[wr_ptr_r]    <= resp_pc_r;
         instr_mem_r[wr_ptr_r] <= imem_rdata_i;
      end
   end

endmodule
